// File: rtl/feature_frame_builder.sv
// Serial feature words -> parallel frame for the detector.
// Optional partial-frame timeout + zero padding: FRAME_TIMEOUT_EN.
module feature_frame_builder #(
  parameter int NUM_FEAT    = 30,
  parameter int DW          = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic          flush,
  output logic [DW-1:0] frame_out [0:NUM_FEAT-1],
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [4:0]    fill_count,
  output logic          pad_flag,
  output logic [1:0]    state
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [4:0] LAST   = 5'(NUM_FEAT - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [4:0]    r_fill;
  logic          r_run;
  logic          r_pad;
  logic [DW-1:0] r_frame [0:NUM_FEAT-1];
  logic          w_accept;
  logic          w_last;
  logic          w_tmo_hit;

  assign w_accept = (r_state == S_FILL) && r_run
                  && sample_valid && !flush;
  assign w_last   = (r_fill == LAST);

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_tmo;
  logic          w_idle;

  assign w_idle = (r_state == S_FILL) && !w_accept
                && !flush && (r_fill != 5'd0)
                && (r_fill != 5'(NUM_FEAT));
  assign w_tmo_hit = w_idle
                   && (r_tmo == TW'(TIMEOUT_CYC - 1));

  // Count idle cycles while a partial frame waits
  always_ff @(posedge Clock) begin
    if (!Rst)
      r_tmo <= '0;
    else if (w_idle && !w_tmo_hit)
      r_tmo <= r_tmo + TW'(1);
    else
      r_tmo <= '0;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (!Rst)
      r_state <= S_FILL;
    else
      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL: begin
        if (w_accept && w_last)
          w_next = S_HOLD;
        else if (w_tmo_hit)
          w_next = S_PAD;
      end
      S_HOLD: begin
        if (frame_ack)
          w_next = S_FILL;
      end
`ifdef FRAME_TIMEOUT_EN
      S_PAD: begin
        if (w_last)
          w_next = S_HOLD;
      end
`endif
      default: w_next = S_FILL;
    endcase
  end

  // Frame storage, fill pointer and pad marker
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      r_run  <= 1'b0;
      r_fill <= '0;
      r_pad  <= 1'b0;
      for (int i = 0; i < NUM_FEAT; i++)
        r_frame[i] <= '0;
    end else begin
      r_run <= 1'b1;
      unique case (r_state)
        S_FILL: begin
          if (flush) begin
            r_fill <= '0;
          end else if (w_accept) begin
            r_frame[r_fill] <= sample_in;
            r_fill <= r_fill + 5'd1;
          end
        end
        S_HOLD: begin
          if (frame_ack) begin
            r_fill <= '0;
            r_pad  <= 1'b0;
          end
        end
`ifdef FRAME_TIMEOUT_EN
        S_PAD: begin
          r_frame[r_fill] <= '0;
          r_fill <= r_fill + 5'd1;
          if (w_last)
            r_pad <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Handshake outputs from state
  always_comb begin
    sample_ready = r_run && (r_state == S_FILL);
    frame_valid  = (r_state == S_HOLD);
  end

  assign state      = r_state;
  assign fill_count = r_fill;
  assign pad_flag   = r_pad;
  assign frame_out  = r_frame;

endmodule

// File: tb/tb_feature_frame_builder.sv
// Directed bench for feature_frame_builder with a frame-level model.
// Timeout scenario selected by FRAME_TIMEOUT_EN.
module tb_feature_frame_builder;

  localparam int N   = 30;
  localparam int DW  = 10;
  localparam int TMO = 20;
`ifdef FRAME_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Rst = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          flush = 1'b0;
  logic          frame_ack = 1'b0;
  logic          sample_ready;
  logic [DW-1:0] frame_out [0:N-1];
  logic          frame_valid;
  logic [4:0]    fill_count;
  logic          pad_flag;
  logic [1:0]    state;

  feature_frame_builder #(
    .NUM_FEAT(N), .DW(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .Clock(Clock), .Rst(Rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .flush(flush),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .fill_count(fill_count),
    .pad_flag(pad_flag),
    .state(state)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  // Model: 0 = collecting, 1 = frame held, 2 = padding
  int m_mode = 0;
  int m_fill = 0;
  int m_tmo = 0;
  bit m_pad = 0;
  bit m_run = 0;
  int m_frame [N];
  bit chk_en = 0;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic model_edge(bit rst, bit v, int d,
                            bit fl, bit ak);
    if (!rst) begin
      m_mode = 0; m_fill = 0; m_pad = 0;
      m_run = 0; m_tmo = 0;
      foreach (m_frame[i]) m_frame[i] = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (fl) begin
          m_fill = 0; m_tmo = 0;
        end else if (v && m_run) begin
          m_frame[m_fill] = d;
          m_fill++;
          m_tmo = 0;
          if (m_fill == N) m_mode = 1;
        end else if (TMO_EN && m_fill > 0
                     && m_fill < N) begin
          m_tmo++;
          if (m_tmo == TMO) begin
            m_mode = 2; m_tmo = 0;
          end
        end
      end
      1: begin
        if (ak) begin
          m_mode = 0; m_fill = 0; m_pad = 0;
        end
      end
      default: begin
        m_frame[m_fill] = 0;
        m_fill++;
        if (m_fill == N) begin
          m_mode = 1; m_pad = 1;
        end
      end
    endcase
    m_run = 1;
  endtask

  task automatic step(bit rst, bit v, int d,
                      bit fl, bit ak);
    Rst = rst;
    sample_valid = v;
    sample_in = DW'(d);
    flush = fl;
    frame_ack = ak;
    @(posedge Clock);
    model_edge(rst, v, d, fl, ak);
    chk_en = 1;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  function automatic int v30(int k);
    if (k == 0) return 284;
    if (k == 1) return 281;
    return 266 + k;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge Clock) begin
    if (chk_en) begin
      int bad;
      bad = 0;
      for (int i = N - 1; i >= 0; i--)
        if (frame_out[i] !== DW'(m_frame[i])) bad = i;
      chk("state", state, m_mode);
      chk("fill_count", fill_count, m_fill);
      chk("frame_valid", frame_valid, m_mode == 1);
      chk("sample_ready", sample_ready,
          m_run && m_mode == 0);
      chk("pad_flag", pad_flag, m_pad);
      chk($sformatf("frame_out[%0d]", bad),
          frame_out[bad], m_frame[bad]);
    end
  end

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);
    #4;
    chk("rst state", state, 0);
    chk("rst fill", fill_count, 0);
    chk("rst ready", sample_ready, 0);
    chk("rst frame5", frame_out[5], 0);
    idle(1);
    chk("ready after rst", sample_ready, 1);

    for (int k = 0; k < N; k++) step(1, 1, v30(k), 0, 0);
    chk("f1 valid", frame_valid, 1);
    chk("f1 ready", sample_ready, 0);
    chk("f1 out0", frame_out[0], 284);
    chk("f1 out29", frame_out[29], 295);

    for (int i = 0; i < 50; i++)
      step(1, i % 2, 7 * i + 1, i == 10, 0);
    chk("hold fill", fill_count, 30);
    chk("hold out1", frame_out[1], 281);
    step(1, 0, 0, 0, 1);
    chk("ack valid", frame_valid, 0);
    chk("ack fill", fill_count, 0);
    chk("ack ready", sample_ready, 1);
    chk("ack keeps out0", frame_out[0], 284);

    for (int k = 0; k < 12; k++)
      step(1, 1, 100 + k, 0, k == 5);
    chk("12 fill", fill_count, 12);
    step(1, 1, 999, 1, 0);
    chk("flush fill", fill_count, 0);
    chk("flush drop", frame_out[12], 278);
    for (int k = 0; k < N; k++) step(1, 1, 500 + k, 0, 0);
    chk("f2 valid", frame_valid, 1);
    chk("f2 out12", frame_out[12], 512);
    step(1, 0, 0, 0, 1);

    for (int k = 0; k < 17; k++) step(1, 1, 40 + k, 0, 0);
    step(0, 1, 57, 0, 0);
    chk("midrst fill", fill_count, 0);
    chk("midrst out3", frame_out[3], 0);
    chk("midrst ready", sample_ready, 0);
    step(0, 0, 0, 0, 0);
    idle(1);

    for (int k = 0; k < 17; k++) step(1, 1, 600 + k, 0, 0);
`ifdef FRAME_TIMEOUT_EN
    idle(19);
    chk("tmo pre", state, 0);
    idle(1);
    chk("tmo pad", state, 2);
    idle(13);
    chk("pad hold", state, 1);
    chk("pad flag", pad_flag, 1);
    chk("pad valid", frame_valid, 1);
    chk("pad out20", frame_out[20], 0);
    chk("pad out16", frame_out[16], 616);
    step(1, 0, 0, 0, 1);
    chk("pad clr", pad_flag, 0);
`else
    idle(5000);
    chk("wait state", state, 0);
    chk("wait fill", fill_count, 17);
    chk("wait valid", frame_valid, 0);
    step(1, 0, 0, 1, 0);
`endif
    idle(2);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
